// File: rtl/serv_alu_seq.sv
// serv_alu_seq: sequencer that runs one 32-bit ALU operation through a bit-serial ALU.
//
// A word-wide request (opcode, rs1, op_b) is accepted over a valid/ready handshake. The operands
// are streamed LSB-first into the ALU W bits per cycle. The serial result is collected and then
// returned over a second valid/ready handshake.
//
// Ports:
//   clk, i_rst_n                      clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready           request handshake; ready only in IDLE
//   i_req_op, i_req_rs1, i_req_op_b   opcode (0 ADD,1 SUB,2 SLT,3 SLTU,4 XOR,5 OR,6 AND,7 EQ)
//   o_rsp_valid/i_rsp_ready           response handshake
//   o_rsp_rd                          result word, stable while o_rsp_valid
//   o_alu_*                           ALU control and data slices; o_alu_buf tied low
//   i_alu_rd, i_alu_cmp               ALU result slice and compare flag
//   i_abort                           only with SERV_ALU_SEQ_ABORT_EN: drops the op in SETUP/RUN
//
// Optional feature macro: SERV_ALU_SEQ_ABORT_EN.
module serv_alu_seq #(
  parameter int unsigned W = 1,
  parameter int unsigned B = W - 1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_rs1,
  input  logic [31:0] i_req_op_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rd,
`ifdef SERV_ALU_SEQ_ABORT_EN
  input  logic        i_abort,
`endif
  output logic        o_alu_en,
  output logic        o_alu_cnt0,
  output logic        o_alu_sub,
  output logic        o_alu_cmp_eq,
  output logic        o_alu_cmp_sig,
  output logic [1:0]  o_alu_bool_op,
  output logic [2:0]  o_alu_rd_sel,
  output logic [B:0]  o_alu_rs1,
  output logic [B:0]  o_alu_op_b,
  output logic [B:0]  o_alu_buf,
  input  logic [B:0]  i_alu_rd,
  input  logic        i_alu_cmp
);

  localparam int unsigned N  = 32 / W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     rs1_q, rs1_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [31:0]     res_q, res_d;
  logic            cmp_q, cmp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_beat;
  logic            is_cmp_op;
  logic [31+W:0]   res_cat;

  assign last_beat = (cnt_q == CW'(N - 1));
  // New slice enters at the MSB end so the word is LSB-aligned after N beats.
  assign res_cat   = {i_alu_rd, res_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          op_d    = i_req_op;
          rs1_d   = i_req_rs1;
          op_b_d  = i_req_op_b;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        rs1_d  = rs1_q >> W;
        op_b_d = op_b_q >> W;
        res_d  = res_cat[31+W:W];
        cnt_d  = cnt_q + 1'b1;
        if (last_beat) begin
          cmp_d   = i_alu_cmp;
          state_d = StDone;
        end
      end
      StDone: begin
        if (i_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef SERV_ALU_SEQ_ABORT_EN
    // Abort wins over RUN->DONE; no response is ever raised for the dropped op.
    if (i_abort && (state_q == StSetup || state_q == StRun)) state_d = StIdle;
`endif
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      rs1_q   <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cmp_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controls are decoded from the registered opcode in every state, so during SETUP the ALU
  // (with o_alu_en low) preloads its carry from o_alu_sub.
  always_comb begin
    o_alu_sub     = 1'b0;
    o_alu_cmp_eq  = 1'b0;
    o_alu_cmp_sig = 1'b0;
    o_alu_bool_op = 2'b01;
    o_alu_rd_sel  = 3'b000;
    is_cmp_op     = 1'b0;
    unique case (op_q)
      3'd0: o_alu_rd_sel = 3'b001;
      3'd1: begin
        o_alu_sub    = 1'b1;
        o_alu_rd_sel = 3'b001;
      end
      3'd2: begin
        o_alu_sub     = 1'b1;
        o_alu_cmp_sig = 1'b1;
        is_cmp_op     = 1'b1;
      end
      3'd3: begin
        o_alu_sub = 1'b1;
        is_cmp_op = 1'b1;
      end
      3'd4: begin
        o_alu_bool_op = 2'b00;
        o_alu_rd_sel  = 3'b100;
      end
      3'd5: begin
        o_alu_bool_op = 2'b10;
        o_alu_rd_sel  = 3'b100;
      end
      3'd6: begin
        o_alu_bool_op = 2'b11;
        o_alu_rd_sel  = 3'b100;
      end
      3'd7: begin
        o_alu_sub    = 1'b1;
        o_alu_cmp_eq = 1'b1;
        is_cmp_op    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_req_ready = (state_q == StIdle);
  assign o_rsp_valid = (state_q == StDone);
  assign o_rsp_rd    = is_cmp_op ? {31'b0, cmp_q} : res_q;
  assign o_alu_en    = (state_q == StRun);
  assign o_alu_cnt0  = (state_q == StRun) && (cnt_q == '0);
  assign o_alu_rs1   = rs1_q[B:0];
  assign o_alu_op_b  = op_b_q[B:0];
  assign o_alu_buf   = '0;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Testbench for serv_alu_seq. A small behavioural serial ALU closes the loop around the DUT.
module tb_serv_alu_seq;
  parameter int unsigned W = 1;
  localparam int unsigned N = 32 / W;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [2:0]  i_req_op = '0;
  logic [31:0] i_req_rs1 = '0;
  logic [31:0] i_req_op_b = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rd;
  logic        i_abort = 1'b0;
  logic        o_alu_en, o_alu_cnt0, o_alu_sub, o_alu_cmp_eq, o_alu_cmp_sig;
  logic [1:0]  o_alu_bool_op;
  logic [2:0]  o_alu_rd_sel;
  logic [W-1:0] o_alu_rs1, o_alu_op_b, o_alu_buf, i_alu_rd;
  logic        i_alu_cmp;

  int checks = 0;
  int failures = 0;
  int edges = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  serv_alu_seq #(.W(W)) dut (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_rs1(i_req_rs1), .i_req_op_b(i_req_op_b),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rd(o_rsp_rd),
`ifdef SERV_ALU_SEQ_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_alu_en(o_alu_en), .o_alu_cnt0(o_alu_cnt0), .o_alu_sub(o_alu_sub),
    .o_alu_cmp_eq(o_alu_cmp_eq), .o_alu_cmp_sig(o_alu_cmp_sig),
    .o_alu_bool_op(o_alu_bool_op), .o_alu_rd_sel(o_alu_rd_sel),
    .o_alu_rs1(o_alu_rs1), .o_alu_op_b(o_alu_op_b), .o_alu_buf(o_alu_buf),
    .i_alu_rd(i_alu_rd), .i_alu_cmp(i_alu_cmp)
  );

  // Serial ALU model: carry preloads with sub while disabled, eq accumulates from cnt0.
  logic         cy_q = 1'b0;
  logic         eq_q = 1'b0;
  logic [W:0]   add_full;
  logic [W-1:0] bool_res;
  logic         eq_now, lt_s, lt_u;

  always_comb begin
    add_full = {1'b0, o_alu_rs1} + {1'b0, o_alu_op_b ^ {W{o_alu_sub}}} + {{W{1'b0}}, cy_q};
    case (o_alu_bool_op)
      2'b00:   bool_res = o_alu_rs1 ^ o_alu_op_b;
      2'b10:   bool_res = o_alu_rs1 | o_alu_op_b;
      2'b11:   bool_res = o_alu_rs1 & o_alu_op_b;
      default: bool_res = '0;
    endcase
    i_alu_rd = (o_alu_rd_sel[0] ? add_full[W-1:0] : '0) | (o_alu_rd_sel[2] ? bool_res : '0);
    eq_now   = (add_full[W-1:0] == '0) && (o_alu_cnt0 || eq_q);
    lt_s     = (o_alu_rs1[W-1] ^ o_alu_op_b[W-1]) ? o_alu_rs1[W-1] : add_full[W-1];
    lt_u     = ~add_full[W];
    i_alu_cmp = o_alu_cmp_eq ? eq_now : (o_alu_cmp_sig ? lt_s : lt_u);
  end

  always @(posedge clk) begin
    cy_q <= o_alu_en ? add_full[W] : o_alu_sub;
    eq_q <= eq_now;
  end

  // Issues one request, scrambles the request fields after the accepting edge, and completes the
  // response handshake. lat counts edges with the accepting edge as 1.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int n = 0;
    i_req_op = op; i_req_rs1 = a; i_req_op_b = b; i_req_valid = 1'b1;
    while (!o_req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    lat = 1;
    i_req_valid = 1'b0; i_req_op = ~op; i_req_rs1 = 32'hDEADBEEF; i_req_op_b = 32'h0BAD0BAD;
    while (!o_rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (!o_rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout op=%0d got rsp_valid=0 want 1 within 200 edges", op);
    end
    res = o_rsp_rd;
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    checks += 5;
    if (o_req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got %b want 1", o_req_ready); end
    if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got %b want 0", o_rsp_valid); end
    if (o_rsp_rd !== 32'h0) begin failures++; $display("FAIL rst_rsp_rd got %h want 0", o_rsp_rd); end
    if (o_alu_en !== 1'b0) begin failures++; $display("FAIL rst_alu_en got %b want 0", o_alu_en); end
    if (o_alu_cnt0 !== 1'b0) begin failures++; $display("FAIL rst_alu_cnt0 got %b want 0", o_alu_cnt0); end
    i_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [31:0] r;
    int lat;
    do_op(3'd0, 32'hFFFFFFFF, 32'h00000001, r, lat);
    checks += 2;
    if (r !== 32'h0) begin failures++; $display("FAIL add_wrap got %h want 00000000", r); end
    if (lat != N + 2) begin failures++; $display("FAIL add_latency got %0d want %0d", lat, N + 2); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] as  [3] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [3] = '{32'd7, 32'd1, 32'd1};
    logic [31:0] exp [3] = '{32'hFFFFFFFE, 32'h1, 32'h0};
    int acc [3];
    int n;
    i_rsp_ready = 1'b1;
    i_req_op = ops[0]; i_req_rs1 = as[0]; i_req_op_b = bs[0]; i_req_valid = 1'b1;
    @(posedge clk); #1;
    acc[0] = edges;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!o_rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (o_rsp_rd !== exp[k] || !o_rsp_valid) begin
        failures++;
        $display("FAIL b2b_result%0d got %h valid=%b want %h", k, o_rsp_rd, o_rsp_valid, exp[k]);
      end
      if (k < 2) begin
        i_req_op = ops[k+1]; i_req_rs1 = as[k+1]; i_req_op_b = bs[k+1];
      end else begin
        i_req_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k < 2) begin
        @(posedge clk); #1;
        acc[k+1] = edges;
        checks++;
        if (acc[k+1] - acc[k] != N + 3) begin
          failures++;
          $display("FAIL b2b_spacing%0d got %0d want %0d", k, acc[k+1] - acc[k], N + 3);
        end
      end
    end
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_bool_eq();
    logic [2:0]  ops [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    logic [31:0] as  [5] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1234, 32'h1234};
    logic [31:0] bs  [5] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h1234, 32'h1235};
    logic [31:0] exp [5] = '{32'h0FF00FF0, 32'hFFF0FFF0, 32'hF000F000, 32'h1, 32'h0};
    logic [31:0] r;
    int lat;
    for (int k = 0; k < 5; k++) begin
      do_op(ops[k], as[k], bs[k], r, lat);
      checks++;
      if (r !== exp[k]) begin failures++; $display("FAIL bool_eq%0d got %h want %h", k, r, exp[k]); end
    end
  endtask

  task automatic test_hold();
    int n = 0;
    i_req_op = 3'd0; i_req_rs1 = 32'h11111111; i_req_op_b = 32'h22222222; i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_op = 3'd4; i_req_rs1 = 32'h0000FFFF; i_req_op_b = 32'h00FF00FF;
    while (!o_rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rd !== 32'h33333333 || o_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_c%0d got valid=%b rd=%h ready=%b want 1 33333333 0",
                 c, o_rsp_valid, o_rsp_rd, o_req_ready);
      end
      @(posedge clk); #1;
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got ready=%b valid=%b want 1 0", o_req_ready, o_rsp_valid);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    checks++;
    if (o_req_ready !== 1'b0) begin failures++; $display("FAIL hold_accept got ready=%b want 0", o_req_ready); end
    n = 0;
    while (!o_rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (o_rsp_rd !== 32'h00FFFF00) begin failures++; $display("FAIL hold_next got %h want 00FFFF00", o_rsp_rd); end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int beat = (N > 10) ? 10 : N / 2;
    int seen = 0;
    logic [31:0] r;
    int lat;
    i_req_op = 3'd0; i_req_rs1 = 32'h12345678; i_req_op_b = 32'h1; i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    for (int k = 0; k <= beat; k++) begin @(posedge clk); #1; end
    i_rst_n = 1'b0;
    #1;
    checks += 5;
    if (o_req_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got %b want 1", o_req_ready); end
    if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %b want 0", o_rsp_valid); end
    if (o_rsp_rd !== 32'h0) begin failures++; $display("FAIL mid_rst_rd got %h want 0", o_rsp_rd); end
    if (o_alu_en !== 1'b0) begin failures++; $display("FAIL mid_rst_en got %b want 0", o_alu_en); end
    if (o_alu_cnt0 !== 1'b0) begin failures++; $display("FAIL mid_rst_cnt0 got %b want 0", o_alu_cnt0); end
    #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got %b want 1", o_req_ready); end
    for (int k = 0; k < 2 * N + 5; k++) begin
      if (o_rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL post_rst_no_rsp got %0d valid cycles want 0", seen); end
    do_op(3'd0, 32'd2, 32'd3, r, lat);
    checks++;
    if (r !== 32'd5) begin failures++; $display("FAIL post_rst_add got %h want 00000005", r); end
  endtask

`ifdef SERV_ALU_SEQ_ABORT_EN
  task automatic test_abort();
    int beat = (N > 5) ? 5 : N - 1;
    int seen = 0;
    int n = 0;
    i_req_op = 3'd1; i_req_rs1 = 32'd9; i_req_op_b = 32'd4; i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    for (int k = 0; k <= beat; k++) begin @(posedge clk); #1; end
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    checks++;
    if (o_alu_en !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_idle got en=%b ready=%b want 0 1", o_alu_en, o_req_ready);
    end
    for (int k = 0; k < 2 * N + 5; k++) begin
      if (o_rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_no_rsp got %0d valid cycles want 0", seen); end
    // Abort in DONE must not drop the pending response.
    i_req_op = 3'd1; i_req_rs1 = 32'd9; i_req_op_b = 32'd4; i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    while (!o_rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_rd !== 32'd5) begin
      failures++;
      $display("FAIL abort_done got valid=%b rd=%h want 1 00000005", o_rsp_valid, o_rsp_rd);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_bool_eq();
    test_hold();
    test_reset_mid_run();
`ifdef SERV_ALU_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
